uart_tx_feeder: RTL and testbench
=================================

Name: uart_tx_feeder

Overview:
Byte-buffering bus master that sits directly upstream of the uart peripheral and drives its register write/read port. The core pushes bytes into an internal FIFO over a valid/ready handshake. The feeder initialises UART_CTRL once after reset. It then polls UART_STATUS and writes each byte to UART_TX only when the transmitter reports not-busy. This removes software polling from the core.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2.
CTRL_INIT, 32'h0000_0001, value written to UART_CTRL after reset (bit0 = TX enable).
BUSY_BIT, 0, UART_STATUS bit meaning "TX busy".
HOLD_CYCLES, 4, wait after each TX write before the next poll; minimum 1.
ADDR_CTRL / ADDR_STATUS / ADDR_TX, 8'h00 / 8'h04 / 8'h0C, uart register offsets.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; asynchronous, active-high
push_valid_i  in  1  core offers a byte
push_data_i  in  8  byte to send
push_ready_o  out  1  FIFO can accept a byte this cycle
flush_i  in  1  synchronous FIFO clear
level_o  out  $clog2(DEPTH)+1  FIFO occupancy
busy_o  out  1  FIFO non-empty or FSM not in IDLE
wen_o  out  1  uart write enable
waddr_o  out  32  uart write address
wdata_o  out  32  uart write data
raddr_o  out  32  uart read address
rdata_i  in  32  uart read data; combinational from raddr_o

Behaviour:
- Reset is asynchronous, active-high, and applies to all state. State=INIT, FIFO empty, level_o=0, wen_o=0, waddr_o=0, wdata_o=0, raddr_o=ADDR_STATUS.
- raddr_o is constant ADDR_STATUS outside reset.
- Bus outputs are Moore outputs decoded from registered state; no combinational path from rdata_i to any output.
- Push handshake:
  - A push is accepted when push_valid_i && push_ready_o at the clock edge.
  - push_ready_o = !full && !flush_i.
  - A push and a pop in the same cycle leave level unchanged.
  - When full, a push is refused; data is held by the producer, never dropped.
- FIFO:
  - Read/write pointers are $clog2(DEPTH) bits and wrap naturally.
  - The head entry is valid whenever level_o != 0.
- FSM:
  - INIT: wen_o=1, waddr_o=ADDR_CTRL, wdata_o=CTRL_INIT for exactly one cycle -> IDLE.
  - IDLE: wen_o=0. If level_o != 0 -> POLL.
  - POLL: sample rdata_i[BUSY_BIT] at the clock edge. 0 -> SEND; 1 -> stay in POLL. There is no timeout.
  - SEND: wen_o=1, waddr_o=ADDR_TX, wdata_o={24'h0, head}. Pop the head at the end of the cycle. -> HOLD, with hold_cnt loaded to HOLD_CYCLES-1.
  - HOLD: wen_o=0. hold_cnt decrements each cycle; when it reaches 0 -> IDLE.
- Latency and throughput:
  - From a push into an empty FIFO while the UART is idle, the first TX write occurs on cycle 3 after acceptance (IDLE, POLL, SEND).
  - Minimum spacing between TX writes is HOLD_CYCLES+3 cycles.
- flush_i:
  - Empties the FIFO at the clock edge and blocks pushes that cycle.
  - If the state is POLL, go to IDLE.
  - If the state is SEND, the bus write still completes that cycle; the pop is subsumed by the clear.
  - INIT and HOLD are unaffected.
- Reset asserted mid-SEND: wen_o drops asynchronously, the FIFO content is lost, and INIT runs again after deassertion.
- busy_o = (level_o != 0) || (state != IDLE).

Decomposition:
- Shared uart package holds the register offsets (CTRL/STATUS/BAUD/TX/RX), the STATUS/CTRL bit indices, and the feeder state enum (INIT, IDLE, POLL, SEND, HOLD). The uart itself and this block both import it.
- One sub-module is natural: sync_fifo (parameters WIDTH, DEPTH; push/pop/flush, full/empty/level). It is reusable for a later RX buffer.

Test Plan:
- Reset release -> exactly one cycle of wen_o=1, waddr_o=0x00, wdata_o=0x1, then wen_o=0 with level_o=0 and busy_o=0.
- Push 0xA5 with rdata_i=0 -> TX write (waddr_o=0x0C, wdata_o=0x000000A5) on cycle 3 after acceptance; level_o returns to 0; busy_o falls after HOLD_CYCLES cycles.
- Push 3 bytes 0x11/0x22/0x33 and hold rdata_i[0]=1 for 20 cycles -> no TX write and FSM in POLL; after release, writes occur in order 0x11, 0x22, 0x33, each spaced 7 cycles apart (HOLD_CYCLES=4).
- Push 17 bytes with the UART held busy -> 16 accepted; push_ready_o=0 at level 16; the 17th is accepted in the cycle after the first SEND.
- Assert flush_i during POLL with level 5 -> level_o=0, FSM in IDLE, no TX write, push ignored in that cycle.
- Assert rst_i mid-SEND -> wen_o=0 immediately (asynchronous), level_o=0; INIT CTRL write follows deassertion.

Source files
------------

// File: rtl/uart_tx_feeder_pkg.sv
// Shared uart register map, bit indices and the TX feeder state encoding.
package uart_tx_feeder_pkg;

  localparam logic [31:0] UART_ADDR_CTRL   = 32'h0000_0000;
  localparam logic [31:0] UART_ADDR_STATUS = 32'h0000_0004;
  localparam logic [31:0] UART_ADDR_BAUD   = 32'h0000_0008;
  localparam logic [31:0] UART_ADDR_TX     = 32'h0000_000C;
  localparam logic [31:0] UART_ADDR_RX     = 32'h0000_0010;

  localparam int unsigned UART_STATUS_TX_BUSY = 0;
  localparam int unsigned UART_CTRL_TX_EN     = 0;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_POLL,
    ST_SEND,
    ST_HOLD
  } feeder_state_t;

endpackage

// File: rtl/uart_tx_feeder_if.sv
// Push handshake from the core plus the uart register port driven by the feeder.
interface uart_tx_feeder_if;
  logic        push_valid_i;
  logic [7:0]  push_data_i;
  logic        push_ready_o;
  logic        wen_o;
  logic [31:0] waddr_o;
  logic [31:0] wdata_o;
  logic [31:0] raddr_o;
  logic [31:0] rdata_i;

  // master: the feeder itself; slave: the core/uart environment around it
  modport master (
    input  push_valid_i, push_data_i, rdata_i,
    output push_ready_o, wen_o, waddr_o, wdata_o, raddr_o
  );

  modport slave (
    output push_valid_i, push_data_i, rdata_i,
    input  push_ready_o, wen_o, waddr_o, wdata_o, raddr_o
  );
endinterface

// File: rtl/uart_tx_feeder_sync_fifo.sv
// Single-clock FIFO with synchronous flush; head entry is presented on o_data while non-empty.
module uart_tx_feeder_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_level == (AW+1)'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_data    = r_mem[r_rptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_flush) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end
endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers core bytes and writes them to the uart TX register whenever STATUS reports not-busy.
module uart_tx_feeder
  import uart_tx_feeder_pkg::*;
#(
  parameter int unsigned DEPTH       = 16,
  parameter logic [31:0] CTRL_INIT   = 32'h0000_0001,
  parameter int unsigned BUSY_BIT    = UART_STATUS_TX_BUSY,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter logic [31:0] ADDR_CTRL   = UART_ADDR_CTRL,
  parameter logic [31:0] ADDR_STATUS = UART_ADDR_STATUS,
  parameter logic [31:0] ADDR_TX     = UART_ADDR_TX
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  uart_tx_feeder_if.master       bus,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   busy_o
);
  localparam int unsigned    HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0]  HOLD_LOAD = HW'(HOLD_CYCLES - 1);

  feeder_state_t r_state;
  logic [HW-1:0] r_hold_cnt;
  logic          w_full;
  logic          w_empty;
  logic          w_ready;
  logic          w_push;
  logic          w_pop;
  logic [7:0]    w_head;
  logic          w_uart_busy;
  logic          w_unused_rdata;
  logic          w_wen;
  logic [31:0]   w_waddr;
  logic [31:0]   w_wdata;

  assign w_ready        = !w_full && !flush_i;
  assign w_push         = bus.push_valid_i && w_ready;
  assign w_pop          = (r_state == ST_SEND);
  assign w_uart_busy    = bus.rdata_i[BUSY_BIT];
  assign w_unused_rdata = ^bus.rdata_i;

  uart_tx_feeder_sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_push  (w_push),
    .i_data  (bus.push_data_i),
    .i_pop   (w_pop),
    .i_flush (flush_i),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level_o)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= ST_INIT;
      r_hold_cnt <= '0;
    end else begin
      unique case (r_state)
        ST_INIT: r_state <= ST_IDLE;
        ST_IDLE: if (!w_empty && !flush_i) r_state <= ST_POLL;
        ST_POLL: begin
          if (flush_i)           r_state <= ST_IDLE;
          else if (!w_uart_busy) r_state <= ST_SEND;
        end
        ST_SEND: begin
          r_state    <= ST_HOLD;
          r_hold_cnt <= HOLD_LOAD;
        end
        ST_HOLD: begin
          if (r_hold_cnt == '0) r_state <= ST_IDLE;
          else                  r_hold_cnt <= r_hold_cnt - 1'b1;
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

  // Decoded from state but masked by rst_i so an in-flight write drops the instant reset asserts
  always_comb begin
    w_wen   = 1'b0;
    w_waddr = '0;
    w_wdata = '0;
    if (!rst_i) begin
      unique case (r_state)
        ST_INIT: begin
          w_wen   = 1'b1;
          w_waddr = ADDR_CTRL;
          w_wdata = CTRL_INIT;
        end
        ST_SEND: begin
          w_wen   = 1'b1;
          w_waddr = ADDR_TX;
          w_wdata = {24'h0, w_head};
        end
        default: ;
      endcase
    end
  end

  assign bus.push_ready_o = w_ready;
  assign bus.wen_o        = w_wen;
  assign bus.waddr_o      = w_waddr;
  assign bus.wdata_o      = w_wdata;
  assign bus.raddr_o      = ADDR_STATUS;
  assign busy_o           = !w_empty || (r_state != ST_IDLE);
endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder: reset/init write, latency, back-pressure, full FIFO, flush, reset mid-SEND.
module tb_uart_tx_feeder;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic [4:0] level;
  logic       busy;
  int         errors = 0;
  int         checks = 0;

  uart_tx_feeder_if bus_if ();

  uart_tx_feeder #(
    .DEPTH       (16),
    .CTRL_INIT   (32'h0000_0001),
    .BUSY_BIT    (0),
    .HOLD_CYCLES (4)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .bus     (bus_if),
    .level_o (level),
    .busy_o  (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] d);
    bus_if.push_valid_i = 1'b1;
    bus_if.push_data_i  = d;
    @(negedge clk);
    bus_if.push_valid_i = 1'b0;
  endtask

  // Advances negedge by negedge until a TX write is visible; n = cycles waited
  task automatic wait_tx(output int n, output logic [31:0] d);
    n = 0;
    d = '0;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (bus_if.wen_o && bus_if.waddr_o == 32'h0C) begin
        n = i;
        d = bus_if.wdata_o;
        break;
      end
    end
    if (n == 0) chk("tx_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic count_tx(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus_if.wen_o && bus_if.waddr_o == 32'h0C) cnt++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cnt;
    logic [31:0] d;
    bus_if.push_valid_i = 1'b0;
    bus_if.push_data_i  = '0;
    bus_if.rdata_i      = '0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_wen",   32'(bus_if.wen_o),   32'd0);
    chk("rst_waddr", bus_if.waddr_o,      32'd0);
    chk("rst_wdata", bus_if.wdata_o,      32'd0);
    chk("rst_raddr", bus_if.raddr_o,      32'h04);
    chk("rst_level", 32'(level),          32'd0);

    // one-cycle CTRL init write after release
    rst = 1'b0;
    #1;
    chk("init_wen",   32'(bus_if.wen_o), 32'd1);
    chk("init_waddr", bus_if.waddr_o,    32'h00);
    chk("init_wdata", bus_if.wdata_o,    32'h01);
    @(negedge clk);
    chk("post_init_wen",   32'(bus_if.wen_o), 32'd0);
    chk("post_init_level", 32'(level),        32'd0);
    chk("post_init_busy",  32'(busy),         32'd0);

    // single byte: TX write on cycle 3 after acceptance
    chk("ready_empty", 32'(bus_if.push_ready_o), 32'd1);
    push_byte(8'hA5);
    chk("cyc1_wen", 32'(bus_if.wen_o), 32'd0);
    wait_tx(n, d);
    chk("first_latency", 32'(n + 1), 32'd3);
    chk("a5_data", d, 32'h0000_00A5);
    repeat (4) begin
      @(negedge clk);
      chk("hold_busy", 32'(busy), 32'd1);
    end
    chk("a5_level", 32'(level), 32'd0);
    @(negedge clk);
    chk("a5_busy_fall", 32'(busy), 32'd0);

    // UART busy stalls the feeder; release drains in order, 7 cycles apart
    bus_if.rdata_i = 32'h1;
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    count_tx(20, cnt);
    chk("stall_no_tx", 32'(cnt),   32'd0);
    chk("stall_level", 32'(level), 32'd3);
    bus_if.rdata_i = 32'h0;
    wait_tx(n, d);
    chk("ord0_data", d, 32'h11);
    wait_tx(n, d);
    chk("ord1_data", d, 32'h22);
    chk("ord1_gap",  32'(n), 32'd7);
    wait_tx(n, d);
    chk("ord2_data", d, 32'h33);
    chk("ord2_gap",  32'(n), 32'd7);
    wait_idle();

    // full FIFO back-pressure; 17th byte taken the cycle after the first SEND
    bus_if.rdata_i = 32'h1;
    for (int i = 0; i < 16; i++) push_byte(8'(8'h50 + i));
    chk("full_level", 32'(level),                32'd16);
    chk("full_ready", 32'(bus_if.push_ready_o),  32'd0);
    bus_if.push_valid_i = 1'b1;
    bus_if.push_data_i  = 8'h60;
    @(negedge clk);
    chk("full_refused_level", 32'(level), 32'd16);
    bus_if.rdata_i = 32'h0;
    wait_tx(n, d);
    chk("full_first_data",  d, 32'h50);
    chk("full_send_ready",  32'(bus_if.push_ready_o), 32'd0);
    @(negedge clk);
    chk("after_send_ready", 32'(bus_if.push_ready_o), 32'd1);
    chk("after_send_level", 32'(level), 32'd15);
    @(negedge clk);
    bus_if.push_valid_i = 1'b0;
    chk("refill_level", 32'(level), 32'd16);
    for (int i = 1; i <= 16; i++) begin
      wait_tx(n, d);
      chk("drain_data", d, 32'(8'h50 + i));
    end
    wait_idle();

    // flush while polling with 5 queued bytes
    bus_if.rdata_i = 32'h1;
    for (int i = 0; i < 5; i++) push_byte(8'(8'h71 + i));
    repeat (2) @(negedge clk);
    chk("pre_flush_level", 32'(level), 32'd5);
    flush = 1'b1;
    bus_if.push_valid_i = 1'b1;
    bus_if.push_data_i  = 8'h77;
    #1;
    chk("flush_ready", 32'(bus_if.push_ready_o), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    bus_if.push_valid_i = 1'b0;
    chk("flush_level", 32'(level), 32'd0);
    chk("flush_busy",  32'(busy),  32'd0);
    bus_if.rdata_i = 32'h0;
    count_tx(10, cnt);
    chk("flush_no_tx", 32'(cnt), 32'd0);

    // reset asserted during SEND
    push_byte(8'h99);
    push_byte(8'h9A);
    wait_tx(n, d);
    chk("pre_rst_data", d, 32'h99);
    rst = 1'b1;
    #1;
    chk("midrst_wen",   32'(bus_if.wen_o), 32'd0);
    chk("midrst_level", 32'(level),        32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reinit_wen",   32'(bus_if.wen_o), 32'd1);
    chk("reinit_waddr", bus_if.waddr_o,    32'h00);
    chk("reinit_wdata", bus_if.wdata_o,    32'h01);
    @(negedge clk);
    chk("reinit_done_wen", 32'(bus_if.wen_o), 32'd0);
    chk("reinit_busy",     32'(busy),         32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
